// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state type and product helper for the multiply/divide unit.
package mdu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Extending both operands to 64 bits keeps the low 64 bits of the
    // product correct for signed and unsigned operands alike.
    function automatic logic [63:0] mul64(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sgn
    );
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/mdu_div_signed.sv
// Combinational quotient/remainder; signed mode truncates toward zero and
// gives the remainder the sign of the dividend.
module mdu_div_signed
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        neg_q;
    logic        neg_r;

    assign abs_a = (sgn && a[31]) ? (32'd0 - a) : a;
    assign abs_b = (sgn && b[31]) ? (32'd0 - b) : b;
    // Zero divisor result is discarded by the caller; avoid X here.
    assign div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign uq    = abs_a / div_b;
    assign ur    = abs_a % div_b;
    assign neg_q = sgn && (a[31] ^ b[31]);
    assign neg_r = sgn && a[31];
    assign quo   = neg_q ? (32'd0 - uq) : uq;
    assign rem   = neg_r ? (32'd0 - ur) : ur;

endmodule

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit with private HI/LO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulation.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    state_e      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] phi, phi_n;
    logic [31:0] plo, plo_n;
    logic        pwe, pwe_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;

    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = mul64(src1, src2, 1'b1);
    assign prod_u = mul64(src1, src2, 1'b0);

    mdu_div_signed u_div (
        .a   (src1),
        .b   (src2),
        .sgn (op == OP_DIV),
        .quo (quo),
        .rem (rem)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phi_n   = phi;
        plo_n   = plo;
        pwe_n   = pwe;
        hi_n    = hi_q;
        lo_n    = lo_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {phi_n, plo_n} = prod_s;
                            pwe_n   = 1'b1;
                            cnt_n   = MC;
                            state_n = S_BUSY;
                        end
                        OP_MULTU: begin
                            {phi_n, plo_n} = prod_u;
                            pwe_n   = 1'b1;
                            cnt_n   = MC;
                            state_n = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            phi_n   = rem;
                            plo_n   = quo;
                            pwe_n   = (src2 != 32'd0);
                            cnt_n   = DC;
                            state_n = S_BUSY;
                        end
                        OP_MTHI: hi_n = src1;
                        OP_MTLO: lo_n = src1;
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            {phi_n, plo_n} = {hi_q, lo_q} + prod_s;
                            pwe_n   = 1'b1;
                            cnt_n   = MC;
                            state_n = S_BUSY;
                        end
                        OP_MADDU: begin
                            {phi_n, plo_n} = {hi_q, lo_q} + prod_u;
                            pwe_n   = 1'b1;
                            cnt_n   = MC;
                            state_n = S_BUSY;
                        end
                        OP_MSUB: begin
                            {phi_n, plo_n} = {hi_q, lo_q} - prod_s;
                            pwe_n   = 1'b1;
                            cnt_n   = MC;
                            state_n = S_BUSY;
                        end
                        OP_MSUBU: begin
                            {phi_n, plo_n} = {hi_q, lo_q} - prod_u;
                            pwe_n   = 1'b1;
                            cnt_n   = MC;
                            state_n = S_BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_n   = 4'd0;
                    state_n = S_IDLE;
                    if (pwe) begin
                        hi_n = phi;
                        lo_n = plo;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            phi   <= 32'd0;
            plo   <= 32'd0;
            pwe   <= 1'b0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            phi   <= phi_n;
            plo   <= plo_n;
            pwe   <= pwe_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

    assign busy = (state == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, results, divide-by-zero, reset abort,
// MTHI/MTLO and the optional accumulate ops.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src1  (src1),
        .src2  (src2),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NOP;
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = OP_NOP;
        src1  = '0;
        src2  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_busy(n);
        check("mult_cyc", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_busy(n);
        check("multu_cyc", n, 32'd5);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_busy(n);
        check("div_cyc", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_busy(n);
        check("divn_lo", lo, 32'hFFFF_FFFD);
        check("divn_hi", hi, 32'h0000_0001);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);

        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_busy(n);
        check("dz_cyc", n, 32'd10);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_busy(n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(OP_MTHI, 32'hAAAA_0000, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(OP_MTLO, 32'h5555, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mt_hi", hi, 32'hAAAA_0000);
        check("mt_lo", lo, 32'h0000_5555);

        issue(OP_MULT, 32'd2, 32'd3);
        issue(OP_DIV, 32'd100, 32'd7);
        wait_busy(n);
        check("ign_cyc", n + 1, 32'd5);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd6);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("late_busy", {31'd0, busy}, 32'd0);
        check("late_hi", hi, 32'd0);
        check("late_lo", lo, 32'd0);

        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_busy(n);
        check("madd_cyc", n, 32'd5);
        check("madd_hi", hi, 32'd1);
        check("madd_lo", lo, 32'd0);
`else
        check("madd_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("madd_hi", hi, 32'd0);
        check("madd_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
